// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// fixed WIDTH-cycle loop followed by a sign-fixup cycle and a done pulse.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               neg_a_q, neg_a_d;
    logic               neg_b_q, neg_b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dbz_q, dbz_d;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH+1:0]   div_sub;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               is_dbz;

    always_comb begin
        sign_a = ((op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110))
                 && SrcA[WIDTH-1];
        sign_b = ((op == 3'b001) || (op == 3'b100) || (op == 3'b110)) && SrcB[WIDTH-1];
        mag_a  = sign_a ? -SrcA : SrcA;
        mag_b  = sign_b ? -SrcB : SrcB;

        mul_sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        // Subtract as add-of-complement: top bit is the carry, 1 means no borrow.
        div_sh  = {acc_q, q_q[WIDTH-1]};
        div_sub = {1'b0, div_sh} + {1'b0, ~{1'b0, m_q}} + (WIDTH+2)'(1);

        prod     = {acc_q, q_q};
        prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -q_q : q_q;
        rem_fix  = neg_a_q ? -acc_q : acc_q;
        is_dbz   = op_q[2] && (m_q == '0);
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        m_d      = m_q;
        q_d      = q_q;
        acc_d    = acc_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = SrcA;
                    neg_a_d = sign_a;
                    neg_b_d = sign_b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    // m holds the multiplicand or divisor; q the multiplier or dividend.
                    m_d     = op[2] ? mag_b : mag_a;
                    q_d     = op[2] ? mag_a : mag_b;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (op_q[2]) begin
                    if (div_sub[WIDTH+1]) begin
                        acc_d = div_sub[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_sh[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIXUP;
                end
            end
            FIXUP: begin
                dbz_d = is_dbz;
                case (op_q)
                    3'b000:                 result_d = prod_fix[WIDTH-1:0];
                    3'b001, 3'b010, 3'b011: result_d = prod_fix[2*WIDTH-1:WIDTH];
                    3'b100, 3'b101:         result_d = is_dbz ? {WIDTH{1'b1}} : quo_fix;
                    default:                result_d = is_dbz ? a_q : rem_fix;
                endcase
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            acc_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            m_q      <= m_d;
            q_q      <= q_d;
            acc_q    <= acc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule
